// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared mode encodings and panel state type for the wash panel
// Contents:
//   MODE_SPIN/MODE_SMALL/MODE_MED/MODE_LARGE - program encodings on the mode output
//   MODE_DEFAULT                             - program selected out of reset (large)
//   panel_state_t                            - panel FSM states OFF/IDLE/RUN
//   next_mode()                              - mode-cycle order with wrap-around
package wash_pkg;

    localparam logic [1:0] MODE_SPIN  = 2'b00;
    localparam logic [1:0] MODE_SMALL = 2'b01;
    localparam logic [1:0] MODE_MED   = 2'b10;
    localparam logic [1:0] MODE_LARGE = 2'b11;

    localparam logic [1:0] MODE_DEFAULT = MODE_LARGE;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } panel_state_t;

    // spin -> small -> medium -> large -> spin
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/wash_panel_btn_debounce.sv
// rtl/wash_panel_btn_debounce.sv - push-button synchronizer, debouncer and press pulse
// Parameter: DEB_CYCLES - cycles the synchronized input must disagree with level before level follows
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - raw button, active-high, asynchronous to clk
//   level - debounced button level
//   press - one-cycle pulse on the debounced 0->1 transition
module btn_debounce
    import wash_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             armed;

    // The synchronizer keeps sampling through reset so that a button held
    // across reset is seen as high immediately afterwards and cannot arm.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], raw};
    end

    // armed: a press may only be reported after the input has been seen low
    // since the last reset, so a press in progress at reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
            armed <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!sync_q[1]) begin
                armed <= 1'b1;
            end
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q[1];
                press <= sync_q[1] & armed;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wash_panel.sv
// rtl/wash_panel.sv - wash machine front panel: four debounced buttons driving an OFF/IDLE/RUN FSM
// Optional feature macro: IDLE_TIMEOUT_EN (IDLE falls back to OFF after TIMEOUT_CYCLES without a press)
// Parameters: DEB_CYCLES (debounce window), TIMEOUT_CYCLES (idle timeout window)
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   btn_power  - raw power button
//   btn_mode   - raw mode-cycle button
//   btn_start  - raw start button
//   btn_cancel - raw cancel button
//   on         - machine power level
//   mode       - selected program (00 spin, 01 small, 10 medium, 11 large)
//   m_pos      - start-run level, high for the whole run
//   busy       - high while in RUN
module wash_panel
    import wash_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_cancel,
    output logic       on,
    output logic [1:0] mode,
    output logic       m_pos,
    output logic       busy
);

    panel_state_t state;
    logic         p_power, p_mode, p_start, p_cancel;
    logic [3:0]   btn_level_unused;
    logic         any_press;
    logic         tmo_hit;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_power (
        .clk(clk), .rst(rst), .raw(btn_power),  .level(btn_level_unused[0]), .press(p_power)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .raw(btn_mode),   .level(btn_level_unused[1]), .press(p_mode)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .raw(btn_start),  .level(btn_level_unused[2]), .press(p_start)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (
        .clk(clk), .rst(rst), .raw(btn_cancel), .level(btn_level_unused[3]), .press(p_cancel)
    );

    assign any_press = p_power | p_mode | p_start | p_cancel;

`ifdef IDLE_TIMEOUT_EN
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts quiet IDLE cycles; any press, including one IDLE ignores,
    // restarts the window.
    always_ff @(posedge clk) begin
        if (rst || state != IDLE || any_press || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == IDLE) && (tmo_cnt == TMO_LAST);
`else
    // Keeps the timeout parameter referenced when the feature is built out.
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    // Within a state the if/else order is the press priority:
    // power > cancel > start > mode; presses a state ignores fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            on    <= 1'b0;
            mode  <= MODE_DEFAULT;
            m_pos <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (p_power) begin
                        state <= IDLE;
                        on    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (p_power) begin
                        state <= OFF;
                        on    <= 1'b0;
                    end else if (p_start) begin
                        state <= RUN;
                        m_pos <= 1'b1;
                        busy  <= 1'b1;
                    end else if (p_mode) begin
                        mode <= next_mode(mode);
                    end else if (tmo_hit) begin
                        state <= OFF;
                        on    <= 1'b0;
                        mode  <= MODE_DEFAULT;
                    end
                end
                RUN: begin
                    if (p_power) begin
                        state <= OFF;
                        on    <= 1'b0;
                        m_pos <= 1'b0;
                        busy  <= 1'b0;
                    end else if (p_cancel) begin
                        state <= IDLE;
                        m_pos <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= OFF;
                    on    <= 1'b0;
                    m_pos <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_panel.sv
// tb/tb_wash_panel.sv - self-checking bench for wash_panel with a sliding-window behavioural model
module tb_wash_panel;

    localparam int DEB = 4;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;   // 0 power, 1 mode, 2 start, 3 cancel
    logic       on, m_pos, busy;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    wash_panel #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .btn_power(btn[0]), .btn_mode(btn[1]), .btn_start(btn[2]), .btn_cancel(btn[3]),
        .on(on), .mode(mode), .m_pos(m_pos), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] hist[$];
    int         since_rst   = 0;
    bit [3:0]   m_level     = '0;
    bit [3:0]   m_armed     = '0;
    bit [3:0]   m_press     = '0;
    int         m_state     = 0;      // 0 OFF, 1 IDLE, 2 RUN
    bit         m_on        = 0;
    bit         m_mpos      = 0;
    bit [1:0]   m_mode      = 2'b11;
    int         idle_age    = 0;
    bit         model_valid = 0;

    initial begin
        for (int i = 0; i < 8; i++) hist.push_back(4'b0000);
    end

    always @(posedge clk) begin
        bit [3:0] p;
        bit [3:0] np;
        int       last;
        bit       all_diff;
        hist.push_back(btn);
        if (hist.size() > 16) void'(hist.pop_front());
        last = hist.size() - 1;
        if (rst) begin
            model_valid = 1;
            since_rst = 0;
            m_level = '0; m_armed = '0; m_press = '0;
            m_state = 0; m_on = 0; m_mpos = 0; m_mode = 2'b11; idle_age = 0;
        end else begin
            p = m_press;
            if (m_state != 1) idle_age = 0;
            case (m_state)
                0: if (p[0]) begin m_state = 1; m_on = 1; end
                1: begin
`ifdef IDLE_TIMEOUT_EN
                    if (p == 4'b0000) idle_age++; else idle_age = 0;
`endif
                    if (p[0]) begin m_state = 0; m_on = 0; end
                    else if (p[2]) begin m_state = 2; m_mpos = 1; end
                    else if (p[1]) m_mode = m_mode + 2'd1;
`ifdef IDLE_TIMEOUT_EN
                    else if (idle_age == TMO) begin m_state = 0; m_on = 0; m_mode = 2'b11; end
`endif
                end
                default: begin
                    if (p[0]) begin m_state = 0; m_on = 0; m_mpos = 0; end
                    else if (p[3]) begin m_state = 1; m_mpos = 0; end
                end
            endcase
            // synchronized value seen at this edge is the raw value two edges back;
            // level follows once the last DEB such values (all post-reset) disagree with it
            since_rst++;
            np = '0;
            for (int b = 0; b < 4; b++) begin
                if (since_rst >= DEB) begin
                    all_diff = 1;
                    for (int k = 0; k < DEB; k++)
                        if (hist[last-2-k][b] == m_level[b]) all_diff = 0;
                    if (all_diff) begin
                        m_level[b] = ~m_level[b];
                        if (m_level[b] && m_armed[b]) np[b] = 1;
                    end
                end
                if (hist[last-2][b] == 1'b0) m_armed[b] = 1;
            end
            m_press = np;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_on",    int'(on),    int'(m_on));
            chk("cyc_mode",  int'(mode),  int'(m_mode));
            chk("cyc_m_pos", int'(m_pos), int'(m_mpos));
            chk("cyc_busy",  int'(busy),  int'(m_state == 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (7) @(negedge clk);
        btn[b] = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        bit [3:0] want;
        bit [1:0] wrap_exp[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_on", on, 0);
        chk("rst_mode", mode, 3);
        chk("rst_m_pos", m_pos, 0);
        chk("rst_busy", busy, 0);

        // clean power press: pulse DEB+2 edges after the rise, output one edge later
        btn[0] = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        chk("lat_on_before", on, 0);
        @(negedge clk);
        chk("lat_on_after", on, 1);
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("release_on", on, 1);

        // bounce then hold: exactly one mode step 11 -> 00
        for (int i = 0; i < 4; i++) begin
            btn[1] = (i % 2 == 0);
            @(negedge clk);
        end
        btn[1] = 1'b1;
        repeat (10) @(negedge clk);
        btn[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce_mode", mode, 0);
        chk("bounce_on", on, 1);

        // bring mode back to 11, then the 5-press wrap sequence
        for (int i = 0; i < 3; i++) press(1);
        chk("pre_wrap_mode", mode, 3);
        for (int i = 0; i < 5; i++) begin
            press(1);
            chk("wrap_mode", mode, wrap_exp[i]);
            chk("wrap_on", on, 1);
            chk("wrap_m_pos", m_pos, 0);
        end

        // run lock at medium
        press(1); press(1);
        chk("sel_med", mode, 2);
        press(2);
        chk("run_m_pos", m_pos, 1);
        chk("run_busy", busy, 1);
        press(1); press(1);
        chk("lock_mode", mode, 2);
        chk("lock_m_pos", m_pos, 1);
        press(3);
        chk("cancel_m_pos", m_pos, 0);
        chk("cancel_busy", busy, 0);
        chk("cancel_on", on, 1);

        // power and start together in IDLE: power wins
        btn[0] = 1'b1; btn[2] = 1'b1;
        repeat (7) @(negedge clk);
        btn[0] = 1'b0; btn[2] = 1'b0;
        repeat (7) @(negedge clk);
        chk("simul_on", on, 0);
        chk("simul_m_pos", m_pos, 0);

        // reset mid-run with start held
        press(0);
        btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_run_m_pos", m_pos, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_on", on, 0);
        chk("midrun_m_pos", m_pos, 0);
        chk("midrun_mode", mode, 3);
        press(0);
        repeat (10) @(negedge clk);
        chk("held_no_start_on", on, 1);
        chk("held_no_start_m_pos", m_pos, 0);
        btn[2] = 1'b0;
        repeat (8) @(negedge clk);
        press(2);
        chk("rearm_m_pos", m_pos, 1);
        press(3);

        // randomized bouncy buttons with occasional reset
        want = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 11) == 0) want[b] = ~want[b];
                btn[b] = ($urandom_range(0, 19) == 0) ? ~want[b] : want[b];
            end
            rst = ($urandom_range(0, 499) == 0);
        end
        btn = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // idle timeout from mode 01
        press(0);
        press(1);
        press(1);
        chk("tmo_setup_mode", mode, 1);
        repeat (60) @(negedge clk);
`ifdef IDLE_TIMEOUT_EN
        chk("tmo_on", on, 0);
        chk("tmo_mode", mode, 3);
`else
        chk("tmo_on", on, 1);
        chk("tmo_mode", mode, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
